// File: rtl/control_unit.sv
// Multicycle MIPS-subset controller: two-process FSM driving datapath selects,
// register loads and the memory write strobe from opCode/funct/eqf/ov.
module control_unit #(
   parameter int unsigned MEM_WAIT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opCode,
   input  logic [5:0] funct,
   input  logic       eqf,
   input  logic       ov,
   output logic       MemCtrl,
   output logic       PCCtrl,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       ALUOutCtrl,
   output logic       EPCCtrl,
   output logic [1:0] IorD,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] RegDst,
   output logic [1:0] LSCtrl,
   output logic [1:0] SSCtrl,
   output logic [1:0] ExcptCtrl,
   output logic [2:0] PCSrc,
   output logic [2:0] ALUCtrl,
   output logic [3:0] DataSrc,
   output logic [4:0] state
);

   typedef enum logic [4:0] {
      st_rst    = 5'd0,  st_fetch = 5'd1,  st_fwait = 5'd2,  st_irld  = 5'd3,
      st_decode = 5'd4,  st_rdec  = 5'd5,  st_alur  = 5'd6,  st_wbr   = 5'd7,
      st_jr     = 5'd8,  st_addi  = 5'd9,  st_wbi   = 5'd10, st_br    = 5'd11,
      st_addr   = 5'd12, st_lrd   = 5'd13, st_lwait = 5'd14, st_lwb   = 5'd15,
      st_stwr   = 5'd16, st_lui   = 5'd17, st_j     = 5'd18, st_jal0  = 5'd19,
      st_jal1   = 5'd20, st_exc   = 5'd21, st_ewait = 5'd22, st_ejmp  = 5'd23
   } state_t;

   localparam logic [2:0] last = 3'(MEM_WAIT - 1);

   state_t     cur, nxt;
   logic [2:0] cnt, cnt_nxt;
   logic [1:0] excode, exc_nxt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cur    <= st_rst;
         cnt    <= '0;
         excode <= '0;
      end else begin
         cur <= nxt;
         cnt <= cnt_nxt;
         if (nxt == st_exc)
            excode <= exc_nxt;
      end
   end

   assign state = cur;

   always_comb begin
      MemCtrl    = 1'b0;
      PCCtrl     = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ALUOutCtrl = 1'b0;
      EPCCtrl    = 1'b0;
      IorD       = '0;
      ALUSrcA    = '0;
      ALUSrcB    = '0;
      RegDst     = '0;
      LSCtrl     = '0;
      SSCtrl     = '0;
      ExcptCtrl  = '0;
      PCSrc      = '0;
      ALUCtrl    = '0;
      DataSrc    = '0;
      nxt        = cur;
      cnt_nxt    = '0;
      exc_nxt    = '0;
      case (cur)
         st_rst: nxt = st_fetch;
         st_fetch: begin
            ALUSrcB = 2'd1;
            ALUCtrl = 3'b001;
            PCCtrl  = 1'b1;
            nxt     = st_fwait;
         end
         st_fwait: begin
            if (cnt == last) nxt = st_irld;
            else             cnt_nxt = cnt + 3'd1;
         end
         st_irld: begin
            IRWrite = 1'b1;
            nxt     = st_decode;
         end
         st_decode: begin
            ALUSrcB    = 2'd3;
            ALUCtrl    = 3'b001;
            ALUOutCtrl = 1'b1;
            case (opCode)
               6'h00:        nxt = st_rdec;
               6'h08:        nxt = st_addi;
               6'h04, 6'h05: nxt = st_br;
               6'h23, 6'h2B: nxt = st_addr;
               6'h0F:        nxt = st_lui;
               6'h02:        nxt = st_j;
               6'h03:        nxt = st_jal0;
               default:      nxt = st_exc;
            endcase
         end
         st_rdec: begin
            case (funct)
               6'h20, 6'h22, 6'h24: nxt = st_alur;
               6'h08:               nxt = st_jr;
               default:             nxt = st_exc;
            endcase
         end
         st_alur: begin
            ALUSrcA    = 2'd1;
            ALUOutCtrl = 1'b1;
            case (funct)
               6'h22:   ALUCtrl = 3'b010;
               6'h24:   ALUCtrl = 3'b011;
               default: ALUCtrl = 3'b001;
            endcase
            // and cannot overflow; ov only diverts add/sub
            if (ov && funct != 6'h24) begin
               nxt     = st_exc;
               exc_nxt = 2'd1;
            end else begin
               nxt = st_wbr;
            end
         end
         st_wbr: begin
            RegDst   = 2'd1;
            RegWrite = 1'b1;
            nxt      = st_fetch;
         end
         st_jr: begin
            ALUSrcA = 2'd1;
            PCCtrl  = 1'b1;
            nxt     = st_fetch;
         end
         st_addi: begin
            ALUSrcA    = 2'd1;
            ALUSrcB    = 2'd2;
            ALUCtrl    = 3'b001;
            ALUOutCtrl = 1'b1;
            if (ov) begin
               nxt     = st_exc;
               exc_nxt = 2'd1;
            end else begin
               nxt = st_wbi;
            end
         end
         st_wbi: begin
            RegWrite = 1'b1;
            nxt      = st_fetch;
         end
         st_br: begin
            ALUSrcA = 2'd1;
            ALUCtrl = 3'b111;
            PCSrc   = 3'd1;
            PCCtrl  = eqf ^ (opCode == 6'h05);
            nxt     = st_fetch;
         end
         st_addr: begin
            ALUSrcA    = 2'd1;
            ALUSrcB    = 2'd2;
            ALUCtrl    = 3'b001;
            ALUOutCtrl = 1'b1;
            nxt        = (opCode == 6'h2B) ? st_stwr : st_lrd;
         end
         st_lrd: begin
            IorD = 2'd2;
            nxt  = st_lwait;
         end
         st_lwait: begin
            IorD = 2'd2;
            if (cnt == last) nxt = st_lwb;
            else             cnt_nxt = cnt + 3'd1;
         end
         st_lwb: begin
            DataSrc  = 4'd1;
            RegWrite = 1'b1;
            nxt      = st_fetch;
         end
         st_stwr: begin
            IorD    = 2'd2;
            MemCtrl = 1'b1;
            nxt     = st_fetch;
         end
         st_lui: begin
            DataSrc  = 4'd6;
            RegWrite = 1'b1;
            nxt      = st_fetch;
         end
         st_j: begin
            PCSrc  = 3'd2;
            PCCtrl = 1'b1;
            nxt    = st_fetch;
         end
         st_jal0: begin
            ALUOutCtrl = 1'b1;
            nxt        = st_jal1;
         end
         st_jal1: begin
            RegDst   = 2'd3;
            RegWrite = 1'b1;
            PCSrc    = 3'd2;
            PCCtrl   = 1'b1;
            nxt      = st_fetch;
         end
         st_exc: begin
            ALUSrcB   = 2'd1;
            ALUCtrl   = 3'b010;
            EPCCtrl   = 1'b1;
            IorD      = 2'd3;
            ExcptCtrl = excode;
            nxt       = st_ewait;
         end
         st_ewait: begin
            IorD      = 2'd3;
            ExcptCtrl = excode;
            if (cnt == last) nxt = st_ejmp;
            else             cnt_nxt = cnt + 3'd1;
         end
         st_ejmp: begin
            LSCtrl    = 2'd2;
            PCSrc     = 3'd3;
            PCCtrl    = 1'b1;
            ExcptCtrl = excode;
            nxt       = st_fetch;
         end
         default: nxt = st_rst;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit (MEM_WAIT=3): walks each instruction class
// through the FSM and checks state codes and control outputs cycle by cycle.
`define CHK(tag, sig, exp) chk(tag, 32'(sig), 32'(exp))

module tb_control_unit;

  localparam int MW = 3;

  localparam int S_RST = 0,  S_FETCH = 1,  S_FWAIT = 2,  S_IRLD = 3,
                 S_DECODE = 4, S_RDEC = 5, S_ALUR = 6,   S_WBR = 7,
                 S_JR = 8,   S_ADDI = 9,   S_WBI = 10,   S_BR = 11,
                 S_ADDR = 12, S_LRD = 13,  S_LWAIT = 14, S_LWB = 15,
                 S_STWR = 16, S_LUI = 17,  S_J = 18,     S_JAL0 = 19,
                 S_JAL1 = 20, S_EXC = 21,  S_EWAIT = 22, S_EJMP = 23;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opCode, funct;
  logic       eqf, ov;
  logic       MemCtrl, PCCtrl, IRWrite, RegWrite, ALUOutCtrl, EPCCtrl;
  logic [1:0] IorD, ALUSrcA, ALUSrcB, RegDst, LSCtrl, SSCtrl, ExcptCtrl;
  logic [2:0] PCSrc, ALUCtrl;
  logic [3:0] DataSrc;
  logic [4:0] state;
  logic [29:0] allouts;

  int tests = 0;
  int fails = 0;

  control_unit #(.MEM_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .opCode(opCode), .funct(funct), .eqf(eqf), .ov(ov),
    .MemCtrl(MemCtrl), .PCCtrl(PCCtrl), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ALUOutCtrl(ALUOutCtrl), .EPCCtrl(EPCCtrl), .IorD(IorD), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .RegDst(RegDst), .LSCtrl(LSCtrl), .SSCtrl(SSCtrl),
    .ExcptCtrl(ExcptCtrl), .PCSrc(PCSrc), .ALUCtrl(ALUCtrl), .DataSrc(DataSrc),
    .state(state)
  );

  assign allouts = {MemCtrl, PCCtrl, IRWrite, RegWrite, ALUOutCtrl, EPCCtrl, IorD,
                    ALUSrcA, ALUSrcB, RegDst, LSCtrl, SSCtrl, ExcptCtrl, PCSrc,
                    ALUCtrl, DataSrc};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expects to be sampling FETCH; leaves the bench sampling DECODE.
  task automatic to_decode(input string t);
    `CHK({t, ".fetch.st"}, state, S_FETCH);
    `CHK({t, ".fetch.pcctrl"}, PCCtrl, 1);
    `CHK({t, ".fetch.srcb"}, ALUSrcB, 1);
    `CHK({t, ".fetch.aluctrl"}, ALUCtrl, 1);
    for (int i = 0; i < MW; i++) begin
      tick();
      `CHK({t, ".fwait.st"}, state, S_FWAIT);
      `CHK({t, ".fwait.iord"}, IorD, 0);
    end
    tick();
    `CHK({t, ".irld.st"}, state, S_IRLD);
    `CHK({t, ".irld.irwrite"}, IRWrite, 1);
    tick();
    `CHK({t, ".decode.st"}, state, S_DECODE);
    `CHK({t, ".decode.srcb"}, ALUSrcB, 3);
    `CHK({t, ".decode.aluout"}, ALUOutCtrl, 1);
  endtask

  // Expects to be sampling EXC; leaves the bench sampling FETCH.
  task automatic exc_flow(input string t, input int code);
    `CHK({t, ".exc.st"}, state, S_EXC);
    `CHK({t, ".exc.code"}, ExcptCtrl, code);
    `CHK({t, ".exc.epc"}, EPCCtrl, 1);
    `CHK({t, ".exc.aluctrl"}, ALUCtrl, 2);
    `CHK({t, ".exc.iord"}, IorD, 3);
    `CHK({t, ".exc.regwrite"}, RegWrite, 0);
    for (int i = 0; i < MW; i++) begin
      tick();
      `CHK({t, ".ewait.st"}, state, S_EWAIT);
      `CHK({t, ".ewait.iord"}, IorD, 3);
      `CHK({t, ".ewait.code"}, ExcptCtrl, code);
    end
    tick();
    `CHK({t, ".ejmp.st"}, state, S_EJMP);
    `CHK({t, ".ejmp.pcsrc"}, PCSrc, 3);
    `CHK({t, ".ejmp.pcctrl"}, PCCtrl, 1);
    `CHK({t, ".ejmp.lsctrl"}, LSCtrl, 2);
    `CHK({t, ".ejmp.code"}, ExcptCtrl, code);
    tick();
    `CHK({t, ".back.st"}, state, S_FETCH);
    `CHK({t, ".back.code"}, ExcptCtrl, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; opCode = '0; funct = '0; eqf = 1'b0; ov = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      `CHK("rst.st", state, S_RST);
      `CHK("rst.outs", allouts, 0);
      tests++;
      if (allouts !== 30'd0 || state !== 5'(S_RST)) begin
        fails++;
        $error("FAIL rst.direct: state %0d outs %0h", state, allouts);
      end
    end
    reset = 1'b1;
    tick();

    tests++;
    if (state !== 5'(S_FETCH) || PCCtrl !== 1'b1 || ALUSrcB !== 2'd1 || ALUCtrl !== 3'b001) begin
      fails++;
      $error("FAIL fetch.direct: state %0d PCCtrl %0b ALUSrcB %0d ALUCtrl %0b",
             state, PCCtrl, ALUSrcB, ALUCtrl);
    end

    // add
    opCode = 6'h00; funct = 6'h20; ov = 1'b0;
    to_decode("add");
    tick(); `CHK("add.rdec.st", state, S_RDEC); `CHK("add.rdec.outs", allouts, 0);
    tick(); `CHK("add.alur.st", state, S_ALUR); `CHK("add.alur.aluctrl", ALUCtrl, 1);
    `CHK("add.alur.srca", ALUSrcA, 1); `CHK("add.alur.regwrite", RegWrite, 0);
    tick(); `CHK("add.wbr.st", state, S_WBR); `CHK("add.wbr.regwrite", RegWrite, 1);
    `CHK("add.wbr.regdst", RegDst, 1);
    tests++;
    if (RegWrite !== 1'b1 || RegDst !== 2'd1) begin
      fails++;
      $error("FAIL add.wbr.direct: RegWrite %0b RegDst %0d", RegWrite, RegDst);
    end
    tick(); `CHK("add.end.st", state, S_FETCH); `CHK("add.end.regwrite", RegWrite, 0);

    // sub with overflow
    funct = 6'h22; ov = 1'b1;
    to_decode("subov");
    tick(); `CHK("subov.rdec.st", state, S_RDEC);
    tick(); `CHK("subov.alur.st", state, S_ALUR); `CHK("subov.alur.aluctrl", ALUCtrl, 2);
    tick(); exc_flow("subov", 1);

    // and ignores ov
    funct = 6'h24;
    to_decode("and");
    tick();
    tick(); `CHK("and.alur.aluctrl", ALUCtrl, 3);
    tick(); `CHK("and.wbr.st", state, S_WBR);
    tick();
    ov = 1'b0;

    // beq / bne with Mealy PCCtrl
    opCode = 6'h04; eqf = 1'b1;
    to_decode("beq");
    tick(); `CHK("beq.st", state, S_BR); `CHK("beq.aluctrl", ALUCtrl, 7);
    `CHK("beq.pcsrc", PCSrc, 1); `CHK("beq.eq1.pcctrl", PCCtrl, 1);
    eqf = 1'b0; #1; `CHK("beq.eq0.pcctrl", PCCtrl, 0);
    tick(); `CHK("beq.end.st", state, S_FETCH);
    opCode = 6'h05; eqf = 1'b1;
    to_decode("bne");
    tick(); `CHK("bne.st", state, S_BR); `CHK("bne.eq1.pcctrl", PCCtrl, 0);
    eqf = 1'b0; #1; `CHK("bne.eq0.pcctrl", PCCtrl, 1);
    tick();

    // sw
    opCode = 6'h2B;
    to_decode("sw");
    tick(); `CHK("sw.addr.st", state, S_ADDR); `CHK("sw.addr.srcb", ALUSrcB, 2);
    `CHK("sw.addr.mem", MemCtrl, 0);
    tick(); `CHK("sw.stwr.st", state, S_STWR); `CHK("sw.stwr.mem", MemCtrl, 1);
    `CHK("sw.stwr.iord", IorD, 2);
    tests++;
    if (MemCtrl !== 1'b1 || IorD !== 2'd2) begin
      fails++;
      $error("FAIL sw.stwr.direct: MemCtrl %0b IorD %0d", MemCtrl, IorD);
    end
    tick(); `CHK("sw.end.st", state, S_FETCH); `CHK("sw.end.mem", MemCtrl, 0);

    // lw
    opCode = 6'h23;
    to_decode("lw");
    tick(); `CHK("lw.addr.st", state, S_ADDR);
    tick(); `CHK("lw.lrd.st", state, S_LRD); `CHK("lw.lrd.iord", IorD, 2);
    for (int i = 0; i < MW; i++) begin
      tick(); `CHK("lw.lwait.st", state, S_LWAIT); `CHK("lw.lwait.iord", IorD, 2);
      tests++;
      if (state !== 5'(S_LWAIT) || RegWrite !== 1'b0) begin
        fails++;
        $error("FAIL lw.lwait.direct: state %0d RegWrite %0b", state, RegWrite);
      end
    end
    tick(); `CHK("lw.lwb.st", state, S_LWB); `CHK("lw.lwb.regwrite", RegWrite, 1);
    `CHK("lw.lwb.datasrc", DataSrc, 1);
    tick(); `CHK("lw.end.st", state, S_FETCH);

    // invalid opcode
    opCode = 6'h3F;
    to_decode("badop");
    tick(); exc_flow("badop", 0);

    // addi with overflow, then a bad funct must relatch code 0
    opCode = 6'h08; ov = 1'b1;
    to_decode("addiov");
    tick(); `CHK("addiov.st", state, S_ADDI);
    tick(); exc_flow("addiov", 1);
    ov = 1'b0; opCode = 6'h00; funct = 6'h2A;
    to_decode("badfn");
    tick(); `CHK("badfn.rdec.st", state, S_RDEC);
    tick(); exc_flow("badfn", 0);

    // addi
    opCode = 6'h08;
    to_decode("addi");
    tick(); `CHK("addi.st", state, S_ADDI); `CHK("addi.srcb", ALUSrcB, 2);
    tick(); `CHK("addi.wbi.st", state, S_WBI); `CHK("addi.wbi.regwrite", RegWrite, 1);
    `CHK("addi.wbi.regdst", RegDst, 0);
    tick();

    // lui
    opCode = 6'h0F;
    to_decode("lui");
    tick(); `CHK("lui.st", state, S_LUI); `CHK("lui.datasrc", DataSrc, 6);
    `CHK("lui.regwrite", RegWrite, 1);
    tick();

    // j
    opCode = 6'h02;
    to_decode("j");
    tick(); `CHK("j.st", state, S_J); `CHK("j.pcsrc", PCSrc, 2); `CHK("j.pcctrl", PCCtrl, 1);
    tick();

    // jal
    opCode = 6'h03;
    to_decode("jal");
    tick(); `CHK("jal0.st", state, S_JAL0); `CHK("jal0.aluout", ALUOutCtrl, 1);
    `CHK("jal0.aluctrl", ALUCtrl, 0);
    tick(); `CHK("jal1.st", state, S_JAL1); `CHK("jal1.regdst", RegDst, 3);
    `CHK("jal1.regwrite", RegWrite, 1); `CHK("jal1.pcsrc", PCSrc, 2);
    `CHK("jal1.pcctrl", PCCtrl, 1);
    tick();

    // jr
    opCode = 6'h00; funct = 6'h08;
    to_decode("jr");
    tick(); `CHK("jr.rdec.st", state, S_RDEC);
    tick(); `CHK("jr.st", state, S_JR); `CHK("jr.srca", ALUSrcA, 1);
    `CHK("jr.pcctrl", PCCtrl, 1); `CHK("jr.aluctrl", ALUCtrl, 0);
    tick();

    // reset during STWR
    opCode = 6'h2B;
    to_decode("rsw");
    tick();
    tick(); `CHK("rsw.stwr.st", state, S_STWR);
    reset = 1'b0;
    tick(); `CHK("rsw.rst.st", state, S_RST); `CHK("rsw.rst.outs", allouts, 0);
    tests++;
    if (MemCtrl !== 1'b0 || RegWrite !== 1'b0 || state !== 5'(S_RST)) begin
      fails++;
      $error("FAIL rsw.rst.direct: state %0d MemCtrl %0b RegWrite %0b",
             state, MemCtrl, RegWrite);
    end
    reset = 1'b1;
    tick(); `CHK("rsw.restart.st", state, S_FETCH);

    // reset mid-LWAIT; the wait counter must restart from zero
    opCode = 6'h23;
    to_decode("rlw");
    tick();
    tick();
    tick(); tick(); `CHK("rlw.lwait.st", state, S_LWAIT);
    reset = 1'b0;
    tick(); `CHK("rlw.rst.st", state, S_RST); `CHK("rlw.rst.outs", allouts, 0);
    reset = 1'b1;
    tick();
    opCode = 6'h02;
    to_decode("rlw.again");
    tick(); `CHK("rlw.j.st", state, S_J);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
